// File: rtl/pwm_timebase_pkg.sv
// Shared definitions for the PWM timebase: counting-mode encodings and port widths.
package pwm_timebase_pkg;

  localparam int PRESCALE_W = 4;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_UPDOWN = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

endpackage

// File: rtl/pwm_timebase_if.sv
// Register-file side of the timebase: configuration in, count state and events out.
interface pwm_timebase_if
  import pwm_timebase_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic                  en;
  logic                  count_reset;
  logic [1:0]            mode;
  logic                  one_shot;
  logic [CNT_W-1:0]      period;
  logic [PRESCALE_W-1:0] prescale;
  logic [CNT_W-1:0]      count_val;
  logic                  dir;
  logic                  ovf_pulse;
  logic                  udf_pulse;
  logic                  running;
  logic [CNT_W-1:0]      period_active;

  modport master (
    output en, count_reset, mode, one_shot, period, prescale,
    input  count_val, dir, ovf_pulse, udf_pulse, running, period_active
  );

  modport slave (
    input  en, count_reset, mode, one_shot, period, prescale,
    output count_val, dir, ovf_pulse, udf_pulse, running, period_active
  );
endinterface

// File: rtl/pwm_prescaler.sv
// Power-of-two clock prescaler: tick fires once every 2^min(prescale, PSC_W) enabled cycles.
module pwm_prescaler
  import pwm_timebase_pkg::*;
#(
  parameter int PSC_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PSC_W-1:0] cnt_q;
  logic [PSC_W-1:0] limit;

  function automatic logic [PSC_W-1:0] psc_limit(input logic [PRESCALE_W-1:0] p);
    int             e;
    logic [PSC_W:0] pow;
    e   = (int'(p) > PSC_W) ? PSC_W : int'(p);
    pow = (PSC_W+1)'(1) << e;
    return PSC_W'(pow - (PSC_W+1)'(1));
  endfunction

  assign limit = psc_limit(prescale);
  assign tick  = en && (cnt_q == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || clr || (cnt_q == limit)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaled up/down/centre-aligned counter with shadowed period and one-shot stop.
module pwm_timebase
  import pwm_timebase_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_timebase_if.slave  tif
);

  mode_e            mode;
  logic             tick;
  logic             upd;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pa_q, pa_d;
  logic             dir_q, dir_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             run_q, run_d;

  assign mode = mode_e'(tif.mode);

  pwm_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tif.en && run_q),
    .clr      (tif.count_reset),
    .prescale (tif.prescale),
    .tick     (tick)
  );

  always_comb begin
    count_d = count_q;
    pa_d    = pa_q;
    dir_d   = dir_q;
    run_d   = run_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    upd     = 1'b0;
    if (tif.count_reset) begin
      count_d = '0;
      dir_d   = (mode != MODE_DOWN);
      run_d   = 1'b1;
      pa_d    = tif.period;
    end else if (!tif.en) begin
      pa_d = tif.period;
    end else if (tick) begin
      case (mode)
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (count_q == '0) begin
            count_d = pa_q;
            udf_d   = 1'b1;
            upd     = 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        MODE_UPDOWN: begin
          // A zero period degenerates to both boundaries on every tick.
          if (pa_q == '0) begin
            count_d = '0;
            dir_d   = 1'b1;
            ovf_d   = 1'b1;
            udf_d   = 1'b1;
            upd     = 1'b1;
          end else if (dir_q && (count_q == pa_q)) begin
            dir_d   = 1'b0;
            count_d = count_q - 1'b1;
            ovf_d   = 1'b1;
          end else if (!dir_q && (count_q == '0)) begin
            dir_d   = 1'b1;
            count_d = count_q + 1'b1;
            udf_d   = 1'b1;
            upd     = 1'b1;
          end else if (dir_q) begin
            count_d = count_q + 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        default: begin
          dir_d = 1'b1;
          if (count_q == pa_q) begin
            count_d = '0;
            ovf_d   = 1'b1;
            upd     = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      endcase
      // The period boundary is the only point where the shadow is taken and one-shot stops.
      if (upd) begin
        pa_d = tif.period;
        if (tif.one_shot) run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      pa_q    <= '0;
      dir_q   <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      run_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      pa_q    <= pa_d;
      dir_q   <= dir_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      run_q   <= run_d;
    end
  end

  assign tif.count_val     = count_q;
  assign tif.period_active = pa_q;
  assign tif.dir           = dir_q;
  assign tif.ovf_pulse     = ovf_q;
  assign tif.udf_pulse     = udf_q;
  assign tif.running       = run_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed bench for pwm_timebase: hand-computed sequences for each counting mode and control path.
module tb_pwm_timebase;
  import pwm_timebase_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pwm_timebase_if #(.CNT_W(16)) bus ();

  pwm_timebase #(.CNT_W(16), .PSC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          mc;
  logic [15:0] ud_cnt [8] = '{16'd1, 16'd2, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2};
  logic        ud_dir [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] sh_cnt [8] = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd1, 16'd2, 16'd0};
  logic [15:0] sh_pa  [8] = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd2, 16'd2, 16'd2, 16'd2};

  initial begin
    rst_n           = 1'b0;
    bus.en          = 1'b0;
    bus.count_reset = 1'b0;
    bus.mode        = MODE_UP;
    bus.one_shot    = 1'b0;
    bus.period      = 16'd3;
    bus.prescale    = 4'd0;
    #12;
    chk("rst_count", bus.count_val, 0);
    chk("rst_dir", bus.dir, 1);
    chk("rst_ovf", bus.ovf_pulse, 0);
    chk("rst_udf", bus.udf_pulse, 0);
    chk("rst_running", bus.running, 1);
    chk("rst_pa", bus.period_active, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up mode, period 3, every clock
    step();
    chk("up_pa_load", bus.period_active, 3);
    bus.en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("up_count", bus.count_val, (k + 1) % 4);
      chk("up_ovf", bus.ovf_pulse, ((k + 1) % 4) == 0);
    end
    chk("up_dir", bus.dir, 1);

    // en=0 freezes the count while the shadow tracks period
    bus.en     = 1'b0;
    bus.period = 16'd9;
    step();
    chk("frz_count", bus.count_val, 1);
    chk("frz_pa", bus.period_active, 9);
    step();
    chk("frz_count2", bus.count_val, 1);

    // Down mode, period 2, divide by 4
    bus.mode        = MODE_DOWN;
    bus.period      = 16'd2;
    bus.prescale    = 4'd2;
    bus.en          = 1'b1;
    bus.count_reset = 1'b1;
    step();
    chk("dn_rst_count", bus.count_val, 0);
    chk("dn_rst_dir", bus.dir, 0);
    chk("dn_pa", bus.period_active, 2);
    bus.count_reset = 1'b0;
    mc = 0;
    for (int n = 1; n <= 16; n++) begin
      logic exp_udf;
      exp_udf = 1'b0;
      step();
      if (n % 4 == 0) begin
        if (mc == 0) begin
          mc      = 2;
          exp_udf = 1'b1;
        end else begin
          mc = mc - 1;
        end
      end
      chk("dn_count", bus.count_val, mc);
      chk("dn_udf", bus.udf_pulse, exp_udf);
    end

    // Up-down mode, period 3
    bus.mode        = MODE_UPDOWN;
    bus.period      = 16'd3;
    bus.prescale    = 4'd0;
    bus.count_reset = 1'b1;
    step();
    chk("ud_rst_dir", bus.dir, 1);
    bus.count_reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("ud_count", bus.count_val, ud_cnt[k]);
      chk("ud_dir", bus.dir, ud_dir[k]);
      chk("ud_ovf", bus.ovf_pulse, k == 3);
      chk("ud_udf", bus.udf_pulse, k == 6);
    end

    // Shadowed period: rewrite mid-period, takes effect at the wrap
    bus.mode        = MODE_UP;
    bus.period      = 16'd5;
    bus.count_reset = 1'b1;
    step();
    bus.count_reset = 1'b0;
    step();
    chk("sh_count1", bus.count_val, 1);
    bus.period = 16'd2;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("sh_count", bus.count_val, sh_cnt[k]);
      chk("sh_pa", bus.period_active, sh_pa[k]);
    end

    // One-shot, up mode, period 2
    bus.period      = 16'd2;
    bus.one_shot    = 1'b1;
    bus.count_reset = 1'b1;
    step();
    chk("os_running0", bus.running, 1);
    bus.count_reset = 1'b0;
    step();
    chk("os_c1", bus.count_val, 1);
    step();
    chk("os_c2", bus.count_val, 2);
    step();
    chk("os_wrap", bus.count_val, 0);
    chk("os_ovf", bus.ovf_pulse, 1);
    chk("os_stopped", bus.running, 0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("os_frozen", bus.count_val, 0);
      chk("os_noovf", bus.ovf_pulse, 0);
    end
    chk("os_still_stopped", bus.running, 0);
    bus.one_shot    = 1'b0;
    bus.count_reset = 1'b1;
    step();
    chk("os_rearm", bus.running, 1);
    bus.count_reset = 1'b0;
    step();
    chk("os_resume", bus.count_val, 1);

    // count_reset mid-run with the prescaler mid-count
    bus.period      = 16'd20;
    bus.prescale    = 4'd1;
    bus.count_reset = 1'b1;
    step();
    bus.count_reset = 1'b0;
    repeat (14) step();
    chk("cr_count7", bus.count_val, 7);
    step();
    chk("cr_hold7", bus.count_val, 7);
    bus.count_reset = 1'b1;
    step();
    chk("cr_count0", bus.count_val, 0);
    chk("cr_ovf", bus.ovf_pulse, 0);
    chk("cr_udf", bus.udf_pulse, 0);
    bus.count_reset = 1'b0;
    step();
    chk("cr_psc_restart", bus.count_val, 0);
    step();
    chk("cr_first_tick", bus.count_val, 1);

    // Asynchronous reset between clock edges
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", bus.count_val, 0);
    chk("ar_pa", bus.period_active, 0);
    chk("ar_dir", bus.dir, 1);
    chk("ar_running", bus.running, 1);
    chk("ar_ovf", bus.ovf_pulse, 0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
